// File: rtl/mem_report_tx.sv
// mem_report_tx: consumes the memory manager's received-number handshake,
// acknowledges each report and serialises it as a UART byte frame:
//   header (MSG_ID_WRONG / MSG_ID_REPLACED), addr bytes MSB-first, data bytes MSB-first.
// Optional build macro MEM_REPORT_OVERRUN_MSG_EN adds a one-byte overrun message
// (MSG_ID_OVERRUN) sent once per rising edge of mem_received_overrun.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a report (or pending overrun)
// HEADER  | presenting the header byte; ack pulses on the entry cycle
// PAYLOAD | presenting addr/data bytes, idx_q selects the byte
// OVR     | presenting the single overrun byte (macro build only)
module mem_report_tx #(
  parameter int          ADDR_WIDTH      = 8,
  parameter int          DATA_WIDTH      = 16,
  parameter logic [7:0]  MSG_ID_WRONG    = 8'h10,
  parameter logic [7:0]  MSG_ID_REPLACED = 8'h11,
  parameter logic [7:0]  MSG_ID_OVERRUN  = 8'h12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem_received_num,
  input  logic                             mem_received_replaced,
  input  logic                             mem_received_valid,
  input  logic                             mem_received_overrun,
  output logic                             mem_received_ack,
  output logic [7:0]                       tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic                             busy
);

  localparam int AB = (ADDR_WIDTH + 7) / 8;
  localparam int DB = (DATA_WIDTH + 7) / 8;
  localparam int NB = AB + DB;
  localparam int PW = NB * 8;
  localparam int IW = $clog2(1 + NB);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    OVR     = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] num_q;
  logic                             replaced_q;
  logic [IW-1:0]                    idx_q;
  logic                             ack_q;
  logic                             take;
  logic                             ovr_go;
  logic [AB*8-1:0]                  addr_ext;
  logic [DB*8-1:0]                  data_ext;
  logic [PW-1:0]                    payload;
  logic [7:0]                       byte_sel;

`ifdef MEM_REPORT_OVERRUN_MSG_EN
  logic ovr_prev_q;
  logic ovr_pend_q;

  // Edge-detect the sticky overrun flag; a rise during a frame waits in ovr_pend_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_prev_q <= 1'b0;
      ovr_pend_q <= 1'b0;
    end else begin
      ovr_prev_q <= mem_received_overrun;
      if (mem_received_overrun && !ovr_prev_q)
        ovr_pend_q <= 1'b1;
      else if (state_q == OVR && tx_ready)
        ovr_pend_q <= 1'b0;
    end
  end

  assign ovr_go = ovr_pend_q;
`else
  logic [8:0] unused_overrun;
  assign unused_overrun = {mem_received_overrun, MSG_ID_OVERRUN};
  assign ovr_go = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and byte-stream outputs.
  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    take     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ovr_go) begin
          state_d = OVR;
        end else if (mem_received_valid) begin
          take    = 1'b1;
          state_d = HEADER;
        end
      end
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = replaced_q ? MSG_ID_REPLACED : MSG_ID_WRONG;
        if (tx_ready) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = byte_sel;
        if (tx_ready && idx_q == IW'(NB - 1)) state_d = IDLE;
      end
`ifdef MEM_REPORT_OVERRUN_MSG_EN
      OVR: begin
        tx_valid = 1'b1;
        tx_data  = MSG_ID_OVERRUN;
        if (tx_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Capture the report, pulse ack on the HEADER entry cycle, and step the byte index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_q      <= '0;
      replaced_q <= 1'b0;
      ack_q      <= 1'b0;
      idx_q      <= '0;
    end else begin
      ack_q <= take;
      if (take) begin
        num_q      <= mem_received_num;
        replaced_q <= mem_received_replaced;
      end
      if (state_q == HEADER && tx_ready)
        idx_q <= '0;
      else if (state_q == PAYLOAD && tx_ready)
        idx_q <= idx_q + IW'(1);
    end
  end

  // Zero-extend the captured fields into the byte-aligned payload and pick the current byte.
  always_comb begin
    addr_ext = '0;
    data_ext = '0;
    addr_ext[ADDR_WIDTH-1:0] = num_q[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    data_ext[DATA_WIDTH-1:0] = num_q[DATA_WIDTH-1:0];
    payload  = {addr_ext, data_ext};
    byte_sel = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (idx_q == IW'(i)) byte_sel = payload[(NB-1-i)*8 +: 8];
    end
  end

  assign mem_received_ack = ack_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_mem_report_tx.sv
// Directed bench for mem_report_tx: default 8/16 instance plus a 10/12 width variant.
module tb_mem_report_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] num;
  logic        replaced, valid, overrun, ack;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, busy;

  logic [21:0] w_num;
  logic        w_replaced, w_valid, w_overrun, w_ack;
  logic [7:0]  w_tx_data;
  logic        w_tx_valid, w_busy;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;
  int ack_base;

  always #5 clk = ~clk;

  always @(negedge clk) if (ack === 1'b1) ack_cnt++;

  mem_report_tx u_dut (
    .clk(clk), .reset(reset),
    .mem_received_num(num), .mem_received_replaced(replaced),
    .mem_received_valid(valid), .mem_received_overrun(overrun),
    .mem_received_ack(ack), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy)
  );

  mem_report_tx #(.ADDR_WIDTH(10), .DATA_WIDTH(12)) u_wide (
    .clk(clk), .reset(reset),
    .mem_received_num(w_num), .mem_received_replaced(w_replaced),
    .mem_received_valid(w_valid), .mem_received_overrun(w_overrun),
    .mem_received_ack(w_ack), .tx_data(w_tx_data), .tx_valid(w_tx_valid),
    .tx_ready(tx_ready), .busy(w_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_valid(input bit wide);
    return wide ? w_tx_valid : tx_valid;
  endfunction

  function automatic logic [7:0] cur_data(input bit wide);
    return wide ? w_tx_data : tx_data;
  endfunction

  // Called at a negedge where the byte should be presented; stalls, then lets it transfer.
  task automatic get_byte(input bit wide, input string tag, input logic [7:0] exp, input int stalls);
    chk({tag, "_valid"}, cur_valid(wide), 1);
    chk({tag, "_data"}, cur_data(wide), exp);
    for (int s = 0; s < stalls; s++) begin
      tx_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_hold_valid"}, cur_valid(wide), 1);
      chk({tag, "_hold_data"}, cur_data(wide), exp);
    end
    tx_ready = 1'b1;
    @(negedge clk);
  endtask

  // Present a report in IDLE and check the ack on the HEADER entry cycle.
  task automatic start_report(input string tag, input logic [23:0] n, input logic r);
    num = n; replaced = r; valid = 1'b1;
    @(negedge clk);
    chk({tag, "_ack"}, ack, 1);
    chk({tag, "_busy"}, busy, 1);
    valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_txv"}, tx_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; num = '0; replaced = 1'b0; valid = 1'b0; overrun = 1'b0;
    w_num = '0; w_replaced = 1'b0; w_valid = 1'b0; w_overrun = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    chk("rst_txv", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_data", tx_data, 0);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("idle0");

    // Wrong number, no backpressure.
    ack_base = ack_cnt;
    start_report("t1", {8'h2A, 16'hBEEF}, 1'b0);
    get_byte(0, "t1_b0", 8'h10, 0);
    chk("t1_ack_once", ack, 0);
    get_byte(0, "t1_b1", 8'h2A, 0);
    get_byte(0, "t1_b2", 8'hBE, 0);
    get_byte(0, "t1_b3", 8'hEF, 0);
    chk_idle("t1_end");
    @(negedge clk);
    chk("t1_ackcnt", ack_cnt - ack_base, 1);

    // Replaced number with backpressure.
    start_report("t2", {8'h03, 16'h0001}, 1'b1);
    get_byte(0, "t2_b0", 8'h11, 0);
    get_byte(0, "t2_b1", 8'h03, 2);
    get_byte(0, "t2_b2", 8'h00, 0);
    get_byte(0, "t2_b3", 8'h01, 1);
    chk_idle("t2_end");
    @(negedge clk);

    // Second report held valid through a frame.
    ack_base = ack_cnt;
    start_report("t3a", {8'h2A, 16'hBEEF}, 1'b0);
    get_byte(0, "t3a_b0", 8'h10, 0);
    num = {8'h04, 16'h1234}; replaced = 1'b0; valid = 1'b1;
    chk("t3_noack1", ack, 0);
    get_byte(0, "t3a_b1", 8'h2A, 0);
    chk("t3_noack2", ack, 0);
    get_byte(0, "t3a_b2", 8'hBE, 0);
    chk("t3_noack3", ack, 0);
    get_byte(0, "t3a_b3", 8'hEF, 0);
    chk_idle("t3_gap");
    chk("t3_gap_ack", ack, 0);
    @(negedge clk);
    chk("t3b_ack", ack, 1);
    valid = 1'b0;
    get_byte(0, "t3b_b0", 8'h10, 0);
    get_byte(0, "t3b_b1", 8'h04, 0);
    get_byte(0, "t3b_b2", 8'h12, 0);
    get_byte(0, "t3b_b3", 8'h34, 0);
    chk_idle("t3_end");
    @(negedge clk);
    chk("t3_ackcnt", ack_cnt - ack_base, 2);

    // Reset mid-frame, then a fresh frame.
    start_report("t4a", {8'h2A, 16'hBEEF}, 1'b0);
    get_byte(0, "t4a_b0", 8'h10, 0);
    get_byte(0, "t4a_b1", 8'h2A, 0);
    reset = 1'b1;
    #1;
    chk("t4_rst_txv", tx_valid, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_ack", ack, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("t4_after");
    @(negedge clk);
    chk_idle("t4_after2");
    start_report("t4b", {8'h2A, 16'hBEEF}, 1'b1);
    get_byte(0, "t4b_b0", 8'h11, 0);
    get_byte(0, "t4b_b1", 8'h2A, 0);
    get_byte(0, "t4b_b2", 8'hBE, 0);
    get_byte(0, "t4b_b3", 8'hEF, 0);
    chk_idle("t4_end");
    @(negedge clk);

    // Overrun rises during a frame while a report is pending.
    start_report("t5a", {8'h05, 16'h0006}, 1'b0);
    get_byte(0, "t5a_b0", 8'h10, 0);
    overrun = 1'b1;
    num = {8'h07, 16'h0008}; replaced = 1'b1; valid = 1'b1;
    get_byte(0, "t5a_b1", 8'h05, 0);
    get_byte(0, "t5a_b2", 8'h00, 0);
    get_byte(0, "t5a_b3", 8'h06, 0);
    chk_idle("t5_gap");
    @(negedge clk);
`ifdef MEM_REPORT_OVERRUN_MSG_EN
    chk("t5_ovr_noack", ack, 0);
    get_byte(0, "t5_ovr", 8'h12, 0);
    chk_idle("t5_ovr_end");
    @(negedge clk);
`endif
    chk("t5b_ack", ack, 1);
    valid = 1'b0;
    get_byte(0, "t5b_b0", 8'h11, 0);
    get_byte(0, "t5b_b1", 8'h07, 0);
    get_byte(0, "t5b_b2", 8'h00, 0);
    get_byte(0, "t5b_b3", 8'h08, 0);
    for (int k = 0; k < 3; k++) begin
      chk_idle("t5_quiet");
      @(negedge clk);
    end
    overrun = 1'b0;

    // Width variant: 10-bit addr, 12-bit data.
    w_num = {10'h3FF, 12'hABC}; w_replaced = 1'b0; w_valid = 1'b1;
    @(negedge clk);
    chk("t6_ack", w_ack, 1);
    w_valid = 1'b0;
    get_byte(1, "t6_b0", 8'h10, 0);
    get_byte(1, "t6_b1", 8'h03, 0);
    get_byte(1, "t6_b2", 8'hFF, 0);
    get_byte(1, "t6_b3", 8'h0A, 0);
    get_byte(1, "t6_b4", 8'hBC, 0);
    chk("t6_end_txv", w_tx_valid, 0);
    chk("t6_end_busy", w_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
